// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the two-channel runtime-programmable clock divider.
package clk_div_pkg;

    localparam int unsigned DEF_CNT_W = 8;

    typedef enum logic {
        EMPTY   = 1'b0,
        PENDING = 1'b1
    } cfg_state_e;

    typedef struct packed {
        logic                 ch;
        logic [DEF_CNT_W-1:0] div;
        logic                 en;
    } cfg_req_t;

    // A ratio below 2 cannot produce a period with both a high and a low phase.
    function automatic logic div_legal(input logic [31:0] d);
        return d >= 32'd2;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, ratio/enable registers and registered output decode.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned      CNT_W   = DEF_CNT_W,
    parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(51),
    parameter logic             RST_EN  = 1'b1
) (
    input  logic             clk_50MHz,
    input  logic             rst_n,
    input  logic             apply,
    input  logic [CNT_W-1:0] new_div,
    input  logic             new_en,
    output logic             en,
    output logic             boundary,
    output logic             div_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             en_q, en_d;
    logic             div_out_q, tick_q;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] half;

    assign last     = div_q - 1'b1;
    assign half     = div_q >> 1;
    assign boundary = en_q && (cnt_q == last);
    assign en       = en_q;
    assign div_out  = div_out_q;
    assign tick     = tick_q;

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        en_d  = en_q;
        if (apply) begin
            cnt_d = '0;
            en_d  = new_en;
            // A disable request may carry a junk ratio; keep the old one then.
            if (div_legal(32'(new_div))) begin
                div_d = new_div;
            end
        end else if (en_q) begin
            cnt_d = boundary ? '0 : cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            div_q     <= RST_DIV;
            en_q      <= RST_EN;
            div_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            en_q      <= en_d;
            div_out_q <= en_q && (cnt_q < half);
            tick_q    <= boundary;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Two-channel clock divider controller: config handshake, single pending slot, sticky error.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned      CNT_W    = DEF_CNT_W,
    parameter logic [CNT_W-1:0] RST_DIV0 = CNT_W'(51),
    parameter logic [CNT_W-1:0] RST_DIV1 = CNT_W'(13),
    parameter logic [1:0]       RST_EN   = 2'b11
) (
    input  logic             clk_50MHz,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_en,
    input  logic             err_clr,
    output logic [1:0]       div_out,
    output logic [1:0]       tick,
    output logic             pend,
    output logic             err
);

    typedef struct packed {
        logic             ch;
        logic [CNT_W-1:0] div;
        logic             en;
    } slot_t;

    cfg_state_e state_q, state_d;
    slot_t      slot_q, slot_d;
    logic       err_q, err_d;

    logic [1:0] ch_en;
    logic [1:0] ch_bnd;
    logic [1:0] apply;
    logic       accept;
    logic       illegal;
    logic       tgt_ready;
    logic       do_apply;

    assign cfg_ready = (state_q == EMPTY);
    assign pend      = (state_q == PENDING);
    assign err       = err_q;

    always_comb begin
        accept    = cfg_valid && cfg_ready;
        illegal   = cfg_en && !div_legal(32'(cfg_div));
        // A disabled target has no boundary to wait for, so it applies at once.
        tgt_ready = ch_bnd[slot_q.ch] || !ch_en[slot_q.ch];
        do_apply  = (state_q == PENDING) && tgt_ready;
        apply     = {do_apply && slot_q.ch, do_apply && !slot_q.ch};

        state_d = state_q;
        slot_d  = slot_q;
        case (state_q)
            EMPTY: begin
                if (accept && !illegal) begin
                    slot_d.ch  = cfg_ch;
                    slot_d.div = cfg_div;
                    slot_d.en  = cfg_en;
                    state_d    = PENDING;
                end
            end
            PENDING: begin
                if (tgt_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (accept && illegal) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            slot_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            err_q   <= err_d;
        end
    end

    clk_div_chan #(
        .CNT_W   (CNT_W),
        .RST_DIV (RST_DIV0),
        .RST_EN  (RST_EN[0])
    ) u_chan0 (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .apply     (apply[0]),
        .new_div   (slot_q.div),
        .new_en    (slot_q.en),
        .en        (ch_en[0]),
        .boundary  (ch_bnd[0]),
        .div_out   (div_out[0]),
        .tick      (tick[0])
    );

    clk_div_chan #(
        .CNT_W   (CNT_W),
        .RST_DIV (RST_DIV1),
        .RST_EN  (RST_EN[1])
    ) u_chan1 (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .apply     (apply[1]),
        .new_div   (slot_q.div),
        .new_en    (slot_q.en),
        .en        (ch_en[1]),
        .boundary  (ch_bnd[1]),
        .div_out   (div_out[1]),
        .tick      (tick[1])
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: cycle model, directed period table, corner sequences.
module tb_clk_div_ctrl;

    logic       clk_50MHz = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_en;
    logic       err_clr;
    logic [1:0] div_out;
    logic [1:0] tick;
    logic       pend;
    logic       err;

    always #10 clk_50MHz = ~clk_50MHz;

    clk_div_ctrl #(
        .CNT_W    (8),
        .RST_DIV0 (8'd51),
        .RST_DIV1 (8'd13),
        .RST_EN   (2'b11)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .err_clr   (err_clr),
        .div_out   (div_out),
        .tick      (tick),
        .pend      (pend),
        .err       (err)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: integer position in the period plus a queue holding the accepted update.
    typedef struct {
        int ch;
        int div;
        bit en;
    } mreq_t;

    int         m_cnt[2];
    int         m_div[2];
    bit         m_en[2];
    logic [1:0] m_dout;
    logic [1:0] m_tick;
    bit         m_err;
    mreq_t      mq[$];

    typedef struct {
        bit ch;
        int div;
        bit en;
        int per;
        int high;
    } vec_t;

    vec_t vecs[6];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_cnt[0] = 0;  m_cnt[1] = 0;
        m_div[0] = 51; m_div[1] = 13;
        m_en[0]  = 1;  m_en[1]  = 1;
        m_dout = 2'b00;
        m_tick = 2'b00;
        m_err  = 0;
        mq.delete();
    endfunction

    function automatic void model_edge();
        bit         ready;
        bit         set_err;
        logic [1:0] dn, tn;
        bit         app[2];
        mreq_t      r;
        mreq_t      nr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ready   = (mq.size() == 0);
        set_err = 0;
        app[0]  = 0;
        app[1]  = 0;
        r       = '{ch: 0, div: 0, en: 0};
        for (int i = 0; i < 2; i++) begin
            dn[i] = m_en[i] && (m_cnt[i] < m_div[i] / 2);
            tn[i] = m_en[i] && (m_cnt[i] == m_div[i] - 1);
        end
        if (!ready) begin
            r = mq[0];
            if (!m_en[r.ch] || m_cnt[r.ch] == m_div[r.ch] - 1) app[r.ch] = 1;
        end
        for (int i = 0; i < 2; i++) begin
            if (app[i]) begin
                m_cnt[i] = 0;
                if (r.div >= 2) m_div[i] = r.div;
                m_en[i] = r.en;
            end else if (m_en[i]) begin
                m_cnt[i] = (m_cnt[i] + 1) % m_div[i];
            end else begin
                m_cnt[i] = 0;
            end
        end
        if (app[0] || app[1]) void'(mq.pop_front());
        if (ready && cfg_valid) begin
            if (cfg_en && cfg_div < 2) begin
                set_err = 1;
            end else begin
                nr.ch  = int'(cfg_ch);
                nr.div = int'(cfg_div);
                nr.en  = cfg_en;
                mq.push_back(nr);
            end
        end
        m_err  = set_err ? 1'b1 : (err_clr ? 1'b0 : m_err);
        m_dout = dn;
        m_tick = tn;
    endfunction

    function automatic void check_outputs();
        bit exp_pend;
        exp_pend = (mq.size() != 0);
        chk("div_out", 32'(div_out), 32'(m_dout));
        chk("tick", 32'(tick), 32'(m_tick));
        chk("pend", 32'(pend), 32'(exp_pend));
        chk("cfg_ready", 32'(cfg_ready), 32'(!exp_pend));
        chk("err", 32'(err), 32'(m_err));
    endfunction

    // Inputs change at negedge; the model steps on the same posedge and outputs are compared 1ns later.
    task automatic step();
        @(posedge clk_50MHz);
        model_edge();
        #1;
        check_outputs();
        @(negedge clk_50MHz);
    endtask

    task automatic do_write(input bit ch, input int div, input bit en);
        bit acc;
        acc       = 0;
        cfg_valid = 1;
        cfg_ch    = ch;
        cfg_div   = 8'(div);
        cfg_en    = en;
        for (int k = 0; k < 600 && !acc; k++) begin
            acc = cfg_ready;
            step();
        end
        cfg_valid = 0;
        chk("write_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 600 && pend; k++) step();
        chk("pend_clears", 32'(pend), 32'd0);
    endtask

    task automatic measure(input bit ch, input int per, input int high);
        int   t, h, tk;
        bit   found;
        logic prev;
        found = 0;
        prev  = div_out[ch];
        for (int k = 0; k < 600 && !found; k++) begin
            step();
            found = !prev && div_out[ch];
            prev  = div_out[ch];
        end
        chk("rise_found", 32'(found), 32'd1);
        t = 0; h = 0; tk = 0; found = 0;
        for (int k = 0; k < 600 && !found; k++) begin
            if (div_out[ch]) h++;
            if (tick[ch]) tk++;
            t++;
            prev = div_out[ch];
            step();
            found = !prev && div_out[ch];
        end
        chk($sformatf("period_ch%0d", ch), 32'(t), 32'(per));
        chk($sformatf("high_ch%0d", ch), 32'(h), 32'(high));
        chk($sformatf("ticks_ch%0d", ch), 32'(tk), 32'd1);
    endtask

    initial begin
        vecs[0] = '{ch: 0, div: 10,  en: 1, per: 10,  high: 5};
        vecs[1] = '{ch: 1, div: 4,   en: 1, per: 4,   high: 2};
        vecs[2] = '{ch: 0, div: 255, en: 1, per: 255, high: 127};
        vecs[3] = '{ch: 1, div: 3,   en: 1, per: 3,   high: 1};
        vecs[4] = '{ch: 0, div: 51,  en: 1, per: 51,  high: 25};
        vecs[5] = '{ch: 1, div: 13,  en: 1, per: 13,  high: 6};

        rst_n     = 0;
        cfg_valid = 0;
        cfg_ch    = 0;
        cfg_div   = 8'd0;
        cfg_en    = 0;
        err_clr   = 0;
        model_reset();
        @(negedge clk_50MHz);
        repeat (3) step();
        rst_n = 1;

        measure(0, 51, 25);
        measure(1, 13, 6);

        for (int v = 0; v < 6; v++) begin
            do_write(vecs[v].ch, vecs[v].div, vecs[v].en);
            wait_idle();
            measure(vecs[v].ch, vecs[v].per, vecs[v].high);
        end

        // Disable ch1, then re-enable it: the enable applies one edge after acceptance.
        do_write(1, 0, 0);
        wait_idle();
        for (int k = 0; k < 30; k++) begin
            step();
            chk("ch1_off", 32'({div_out[1], tick[1]}), 32'd0);
        end
        do_write(1, 4, 1);
        chk("enable_pending", 32'(pend), 32'd1);
        step();
        chk("enable_applied", 32'(pend), 32'd0);
        measure(1, 4, 2);

        // Illegal ratio, then a clear racing a second illegal request.
        do_write(0, 1, 1);
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_no_pend", 32'(pend), 32'd0);
        err_clr = 1;
        do_write(0, 0, 1);
        err_clr = 0;
        chk("set_beats_clr", 32'(err), 32'd1);
        err_clr = 1;
        step();
        err_clr = 0;
        chk("err_cleared", 32'(err), 32'd0);
        measure(0, 51, 25);

        // cfg_valid held high across pending periods.
        cfg_valid = 1; cfg_ch = 0; cfg_div = 8'd6; cfg_en = 1;
        repeat (40) step();
        cfg_ch = 1; cfg_div = 8'd5;
        repeat (30) step();
        cfg_valid = 0;
        wait_idle();
        measure(0, 6, 3);
        measure(1, 5, 2);

        for (int k = 0; k < 2500; k++) begin
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_ch    = 1'($urandom_range(0, 1));
            cfg_div   = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 24));
            cfg_en    = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 15) == 0);
            step();
        end
        cfg_valid = 0;
        err_clr   = 0;
        wait_idle();

        // Reset asserted mid-period while an update is pending.
        do_write(0, 50, 1);
        wait_idle();
        do_write(0, 200, 1);
        repeat (3) step();
        chk("pend_before_rst", 32'(pend), 32'd1);
        rst_n = 0;
        #1;
        model_reset();
        chk("rst_div_out", 32'(div_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_pend", 32'(pend), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk_50MHz);
        repeat (2) step();
        rst_n = 1;
        measure(0, 51, 25);
        measure(1, 13, 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
